// File: rtl/anita_trig_pkg.sv
// Shared constants and types for the ANITA L2 phi-sector trigger.
package anita_trig_pkg;

  // Ring positions inside each 3-bit per-sector L1 group.
  localparam int RING_BOT = 0;
  localparam int RING_MID = 1;
  localparam int RING_TOP = 2;

  // Bit positions inside the global coincidence enable word.
  localparam int CO_BM = 0;
  localparam int CO_MT = 1;
  localparam int CO_BT = 2;

  // Per-sector L2 pulse state machine.
  typedef enum logic [1:0] {
    L2_IDLE = 2'd0,
    L2_FIRE = 2'd1,
    L2_HOLD = 2'd2
  } l2_state_e;

  // Largest of three values, used to size the shared counter width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/anita_l2_phi_trigger_sector.sv
// One phi sector: window counters, coincidence logic and the L2 pulse FSM.
//
// Window counters: a source flag in cycle c loads W at c+1, then counts down
// to 0 and holds. The window is open while the source is high or the count is
// non-zero, i.e. over cycles c..c+W. Reset closes every window.
module l2_phi_sector
  import anita_trig_pkg::*;
#(
  parameter int BM_WINDOW = 1,
  parameter int MT_WINDOW = 2,
  parameter int BT_WINDOW = 3,
  parameter int L2_WIDTH  = 3,
  parameter int HOLDOFF   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] l1_q,
  input  logic [2:0] coinc_en,
  output logic       l2,
  output logic       l2_pulse
);

  localparam int CW = $clog2(max3(max3(BM_WINDOW, MT_WINDOW, BT_WINDOW),
                                  L2_WIDTH, HOLDOFF) + 1);
  localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  logic          bot_q, mid_q, top_q;
  logic [CW-1:0] bot_bm_cnt, mid_bm_cnt, mid_mt_cnt, bot_bt_cnt;
  logic          bot_open_bm, mid_open_bm, mid_open_mt, bot_open_bt;
  logic          bm, mt, bt, hit;
  l2_state_e     state;
  logic [CW-1:0] wcnt;

  assign bot_q = l1_q[RING_BOT];
  assign mid_q = l1_q[RING_MID];
  assign top_q = l1_q[RING_TOP];

  // Window counters: reload on source, saturating decrement otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bot_bm_cnt <= '0;
      mid_bm_cnt <= '0;
      mid_mt_cnt <= '0;
      bot_bt_cnt <= '0;
    end else begin
      if (bot_q)                bot_bm_cnt <= CW'(BM_WINDOW);
      else if (bot_bm_cnt != 0) bot_bm_cnt <= bot_bm_cnt - CW'(1);
      if (mid_q)                mid_bm_cnt <= CW'(BM_WINDOW);
      else if (mid_bm_cnt != 0) mid_bm_cnt <= mid_bm_cnt - CW'(1);
      if (mid_q)                mid_mt_cnt <= CW'(MT_WINDOW);
      else if (mid_mt_cnt != 0) mid_mt_cnt <= mid_mt_cnt - CW'(1);
      if (bot_q)                bot_bt_cnt <= CW'(BT_WINDOW);
      else if (bot_bt_cnt != 0) bot_bt_cnt <= bot_bt_cnt - CW'(1);
    end
  end

  assign bot_open_bm = bot_q | (bot_bm_cnt != 0);
  assign mid_open_bm = mid_q | (mid_bm_cnt != 0);
  assign mid_open_mt = mid_q | (mid_mt_cnt != 0);
  assign bot_open_bt = bot_q | (bot_bt_cnt != 0);

  // Top only ever closes a window, so a top ahead of mid/bot never coincides.
  assign bm  = (bot_q & mid_open_bm) | (mid_q & bot_open_bm);
  assign mt  = top_q & mid_open_mt;
  assign bt  = top_q & bot_open_bt;
  assign hit = (bm & coinc_en[CO_BM]) | (mt & coinc_en[CO_MT]) |
               (bt & coinc_en[CO_BT]);

  // L2 FSM: fixed-width pulse, then holdoff; hits outside IDLE are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= L2_IDLE;
      wcnt     <= '0;
      l2       <= 1'b0;
      l2_pulse <= 1'b0;
    end else begin
      l2_pulse <= 1'b0;
      case (state)
        L2_IDLE: begin
          if (hit) begin
            state    <= L2_FIRE;
            wcnt     <= CW'(L2_WIDTH - 1);
            l2       <= 1'b1;
            l2_pulse <= 1'b1;
          end
        end
        L2_FIRE: begin
          if (wcnt == 0) begin
            l2 <= 1'b0;
            if (HOLDOFF == 0) begin
              state <= L2_IDLE;
            end else begin
              state <= L2_HOLD;
              wcnt  <= CW'(HOLD_LOAD);
            end
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        L2_HOLD: begin
          if (wcnt == 0) state <= L2_IDLE;
          else           wcnt  <= wcnt - CW'(1);
        end
        default: begin
          state <= L2_IDLE;
          l2    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/anita_l2_phi_trigger.sv
// ANITA L2 coincidence trigger: conditions L1 flags and runs NPHI
// independent sector engines.
module anita_l2_phi_trigger
  import anita_trig_pkg::*;
#(
  parameter int NPHI      = 2,
  parameter int BM_WINDOW = 1,
  parameter int MT_WINDOW = 2,
  parameter int BT_WINDOW = 3,
  parameter int L2_WIDTH  = 3,
  parameter int HOLDOFF   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3*NPHI-1:0] l1_i,
  input  logic [3*NPHI-1:0] mask_i,
  input  logic [3*NPHI-1:0] force_i,
  input  logic [2:0]        coinc_en_i,
  output logic [3*NPHI-1:0] l1_flag_o,
  output logic [NPHI-1:0]   l2_o,
  output logic [NPHI-1:0]   l2_pulse_o
);

  logic [3*NPHI-1:0] l1_q;

  // Conditioning register: mask first, then force.
  always_ff @(posedge clk_i) begin
    if (rst_i) l1_q <= '0;
    else       l1_q <= (l1_i & ~mask_i) | force_i;
  end

  assign l1_flag_o = l1_q;

  for (genvar p = 0; p < NPHI; p++) begin : g_sector
    l2_phi_sector #(
      .BM_WINDOW(BM_WINDOW),
      .MT_WINDOW(MT_WINDOW),
      .BT_WINDOW(BT_WINDOW),
      .L2_WIDTH (L2_WIDTH),
      .HOLDOFF  (HOLDOFF)
    ) u_sector (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .l1_q    (l1_q[3*p +: 3]),
      .coinc_en(coinc_en_i),
      .l2      (l2_o[p]),
      .l2_pulse(l2_pulse_o[p])
    );
  end

endmodule

// File: tb/tb_anita_l2_phi_trigger.sv
// Bench for anita_l2_phi_trigger: directed scenarios plus random traffic,
// every cycle compared against a history-based reference model.
module tb_anita_l2_phi_trigger;

  localparam int NPHI = 2;
  localparam int NB   = 3 * NPHI;
  localparam int BMW  = 1;
  localparam int MTW  = 2;
  localparam int BTW  = 3;
  localparam int L2W  = 3;
  localparam int HO   = 4;
  localparam int HMAX = 4000;
  localparam int OMAX = 200;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1;
  logic [NB-1:0]   l1_i = '0;
  logic [NB-1:0]   mask_i = '0;
  logic [NB-1:0]   force_i = '0;
  logic [2:0]      coinc_en_i = 3'b111;
  logic [NB-1:0]   l1_flag_o;
  logic [NPHI-1:0] l2_o;
  logic [NPHI-1:0] l2_pulse_o;

  anita_l2_phi_trigger #(
    .NPHI(NPHI), .BM_WINDOW(BMW), .MT_WINDOW(MTW), .BT_WINDOW(BTW),
    .L2_WIDTH(L2W), .HOLDOFF(HO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .l1_i      (l1_i),
    .mask_i    (mask_i),
    .force_i   (force_i),
    .coinc_en_i(coinc_en_i),
    .l1_flag_o (l1_flag_o),
    .l2_o      (l2_o),
    .l2_pulse_o(l2_pulse_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: conditioned-flag history per cycle, last reset cycle,
  // and per-sector pulse start / earliest re-arm cycle.
  logic [NB-1:0]   hist [0:HMAX];
  int              g = 0;
  int              last_rst = -1;
  int              fire_start [NPHI];
  int              next_idle [NPHI];

  // Observations of the current directed scenario, indexed by relative cycle.
  logic [NB-1:0]   obs_flag [0:OMAX-1];
  logic [NPHI-1:0] obs_l2 [0:OMAX-1];
  logic [NPHI-1:0] obs_pulse [0:OMAX-1];
  int              base = 0;
  int              ev_c[$];
  int              ev_b[$];

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, o, e, g);
    end
  endtask

  // Window of width w on flag b is open at t if b was high in any
  // cycle t-w..t that came after the last reset.
  function automatic bit win_open(input int t, input int b, input int w);
    int s;
    for (int k = 0; k <= w; k++) begin
      s = t - k;
      if (s > last_rst && s >= 0 && hist[s][b] === 1'b1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Driver: one cycle of stimulus, model update, and output comparison.
  task automatic step(input logic [NB-1:0] l1v, input logic rstv);
    logic [NB-1:0]   e_flag;
    logic [NPHI-1:0] e_l2, e_pl;
    bit              bot, mid, top, bm, mt, bt, hit;
    int              t, rel;
    @(negedge clk);
    l1_i  = l1v;
    rst_i = rstv;
    t = g;
    hist[t+1] = rstv ? '0 : ((l1v & ~mask_i) | force_i);
    for (int p = 0; p < NPHI; p++) begin
      if (rstv) begin
        fire_start[p] = -1000;
        next_idle[p]  = t + 1;
      end else begin
        bot = hist[t][3*p];
        mid = hist[t][3*p+1];
        top = hist[t][3*p+2];
        bm  = (bot && win_open(t, 3*p+1, BMW)) || (mid && win_open(t, 3*p, BMW));
        mt  = top && win_open(t, 3*p+1, MTW);
        bt  = top && win_open(t, 3*p, BTW);
        hit = (bm && coinc_en_i[0]) || (mt && coinc_en_i[1]) || (bt && coinc_en_i[2]);
        if (t >= next_idle[p] && hit) begin
          fire_start[p] = t + 1;
          next_idle[p]  = t + 1 + L2W + HO;
        end
      end
      e_l2[p] = (t + 1 >= fire_start[p]) && (t + 1 < fire_start[p] + L2W);
      e_pl[p] = (t + 1 == fire_start[p]);
    end
    if (rstv) last_rst = t;
    e_flag = hist[t+1];
    @(posedge clk);
    #1;
    check("l1_flag", 32'(l1_flag_o), 32'(e_flag));
    check("l2", 32'(l2_o), 32'(e_l2));
    check("l2_pulse", 32'(l2_pulse_o), 32'(e_pl));
    rel = t + 1 - base;
    if (rel >= 0 && rel < OMAX) begin
      obs_flag[rel]  = l1_flag_o;
      obs_l2[rel]    = l2_o;
      obs_pulse[rel] = l2_pulse_o;
    end
    if (g < HMAX - 1) g++;
  endtask

  task automatic add_ev(input int c, input int b);
    ev_c.push_back(c);
    ev_b.push_back(b);
  endtask

  // Scenario: reset at relative cycle 0 (and at rst_c if >= 0), then events.
  task automatic run_scen(input int rst_c, input int len);
    logic [NB-1:0] l1v;
    for (int r = 0; r < OMAX; r++) begin
      obs_flag[r] = '0; obs_l2[r] = '0; obs_pulse[r] = '0;
    end
    base = g;
    for (int r = 0; r < len; r++) begin
      l1v = '0;
      for (int e = 0; e < ev_c.size(); e++)
        if (ev_c[e] == r) l1v[ev_b[e]] = 1'b1;
      step(l1v, (r == 0) || (r == rst_c));
    end
    ev_c.delete();
    ev_b.delete();
  endtask

  function automatic int count_l2(input int p, input int len);
    int n = 0;
    for (int r = 0; r < len && r < OMAX; r++) if (obs_l2[r][p]) n++;
    return n;
  endfunction

  function automatic int count_pulse(input int p, input int len);
    int n = 0;
    for (int r = 0; r < len && r < OMAX; r++) if (obs_pulse[r][p]) n++;
    return n;
  endfunction

  initial begin
    logic [NB-1:0] l1v;
    for (int i = 0; i <= HMAX; i++) hist[i] = '0;
    for (int p = 0; p < NPHI; p++) begin
      fire_start[p] = -1000;
      next_idle[p]  = 0;
    end

    // Reset state
    step('0, 1'b1);
    step('0, 1'b0);
    check("reset_l2", 32'(l2_o), 32'h0);

    // 1. Mid/top window
    add_ev(10, 1); add_ev(12, 2);
    run_scen(-1, 25);
    check("mt_l2_13", 32'(obs_l2[13][0]), 32'h0);
    check("mt_l2_14", 32'(obs_l2[14][0]), 32'h1);
    check("mt_l2_16", 32'(obs_l2[16][0]), 32'h1);
    check("mt_l2_17", 32'(obs_l2[17][0]), 32'h0);
    check("mt_pulse_14", 32'(obs_pulse[14][0]), 32'h1);
    check("mt_pulse_cnt", 32'(count_pulse(0, 25)), 32'd1);
    check("mt_flag_11", 32'(obs_flag[11]), 32'h02);
    add_ev(10, 1); add_ev(13, 2);
    run_scen(-1, 25);
    check("mt_late_none", 32'(count_l2(0, 25)), 32'd0);

    // 2. Bot/top window and ordering
    add_ev(20, 3); add_ev(23, 5);
    run_scen(-1, 35);
    check("bt_l2_24", 32'(obs_l2[24][1]), 32'h0);
    check("bt_l2_25", 32'(obs_l2[25][1]), 32'h1);
    check("bt_l2_27", 32'(obs_l2[27][1]), 32'h1);
    check("bt_l2_28", 32'(obs_l2[28][1]), 32'h0);
    check("bt_sec0_quiet", 32'(count_l2(0, 35)), 32'd0);
    add_ev(20, 3); add_ev(24, 5);
    run_scen(-1, 35);
    check("bt_late_none", 32'(count_l2(1, 35)), 32'd0);
    add_ev(19, 5); add_ev(20, 3);
    run_scen(-1, 35);
    check("bt_order_none", 32'(count_l2(1, 35)), 32'd0);

    // 3. Bot/mid, both orders
    add_ev(30, 0); add_ev(31, 1);
    run_scen(-1, 40);
    check("bm_l2_32", 32'(obs_l2[32][0]), 32'h0);
    check("bm_l2_33", 32'(obs_l2[33][0]), 32'h1);
    add_ev(30, 1); add_ev(31, 0);
    run_scen(-1, 40);
    check("mb_l2_33", 32'(obs_l2[33][0]), 32'h1);
    add_ev(30, 0); add_ev(32, 1);
    run_scen(-1, 40);
    check("bm_late_none", 32'(count_l2(0, 40)), 32'd0);

    // 4. Holdoff drops a second hit
    add_ev(39, 1); add_ev(40, 2);
    add_ev(44, 1); add_ev(45, 2);
    add_ev(48, 1); add_ev(49, 2);
    run_scen(-1, 60);
    check("ho_l2_42", 32'(obs_l2[42][0]), 32'h1);
    check("ho_l2_44", 32'(obs_l2[44][0]), 32'h1);
    check("ho_l2_45", 32'(obs_l2[45][0]), 32'h0);
    check("ho_l2_47", 32'(obs_l2[47][0]), 32'h0);
    check("ho_pulse_51", 32'(obs_pulse[51][0]), 32'h1);
    check("ho_pulse_cnt", 32'(count_pulse(0, 60)), 32'd2);

    // 5a. Enables suppress the mid/top coincidence
    coinc_en_i = 3'b101;
    add_ev(10, 1); add_ev(12, 2);
    run_scen(-1, 25);
    check("en_mt_off", 32'(count_l2(0, 25)), 32'd0);
    coinc_en_i = 3'b111;

    // 5b. Mask on sector 1 bottom
    mask_i = 6'b001000;
    add_ev(30, 0); add_ev(31, 1); add_ev(30, 3); add_ev(31, 4);
    run_scen(-1, 40);
    check("mask_sec0_fires", 32'(obs_l2[33][0]), 32'h1);
    check("mask_sec1_none", 32'(count_l2(1, 40)), 32'd0);
    mask_i = '0;

    // 5c. Forced top plus a single mid
    force_i = 6'b000100;
    add_ev(60, 1);
    run_scen(-1, 70);
    check("force_l2_61", 32'(obs_l2[61][0]), 32'h0);
    check("force_l2_62", 32'(obs_l2[62][0]), 32'h1);
    check("force_flag_61", 32'(obs_flag[61]), 32'h06);
    force_i = '0;

    // 6. Reset mid-operation
    add_ev(10, 1); add_ev(12, 2);
    run_scen(15, 25);
    check("rst_l2_15", 32'(obs_l2[15][0]), 32'h1);
    check("rst_l2_16", 32'(obs_l2[16]), 32'h0);
    check("rst_pulse_16", 32'(obs_pulse[16]), 32'h0);
    check("rst_flag_16", 32'(obs_flag[16]), 32'h0);
    add_ev(14, 1); add_ev(16, 2);
    run_scen(15, 30);
    check("rst_window_closed", 32'(count_l2(0, 30)), 32'd0);

    // Random traffic against the model
    base = HMAX;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        coinc_en_i = 3'($urandom_range(0, 7));
        mask_i     = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
        force_i    = ($urandom_range(0, 5) == 0) ? NB'(1 << $urandom_range(0, NB-1)) : '0;
      end
      l1v = '0;
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 5) == 0) l1v[b] = 1'b1;
      step(l1v, $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
